// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter (pipeline vs. host port).
package dmem_arb_pkg;

    localparam int unsigned DEF_DATA_WIDTH    = 64;
    localparam int unsigned DEF_ADDR_WIDTH    = 8;
    localparam int unsigned DEF_HOST_MAX_WAIT = 4;

    // Last winner of the memory port; HOST_LOCK keeps the pipeline out.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PIPE_OWN  = 2'd1,
        ST_HOST_OWN  = 2'd2,
        ST_HOST_LOCK = 2'd3
    } arb_state_t;

    // Width of a counter that must reach max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the pipeline memory stage and a host port.
// Define DMEM_ARB_ROUND_ROBIN_EN to alternate winners on contention instead of fixed pipeline priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int unsigned HOST_MAX_WAIT = DEF_HOST_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  pipe_req,
    input  logic                  pipe_we,
    input  logic [ADDR_WIDTH-1:0] pipe_addr,
    input  logic [DATA_WIDTH-1:0] pipe_wdata,
    output logic                  pipe_gnt,
    output logic                  pipe_stall,
    output logic                  pipe_rvalid,
    output logic [DATA_WIDTH-1:0] pipe_rdata,

    input  logic                  host_req,
    input  logic                  host_we,
    input  logic                  host_lock,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,

    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned WAIT_W = cnt_width(HOST_MAX_WAIT);

    arb_state_t            state;
    arb_state_t            state_next;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [WAIT_W-1:0]     wait_cnt_next;
    logic                  host_forced;
    logic                  pipe_first;
    logic                  pipe_pend;
    logic                  host_pend;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] pipe_rdata_q;
    logic [DATA_WIDTH-1:0] host_rdata_q;

    // Grant decision: combinational from current requests and arbiter state.
    always_comb begin
        pipe_gnt    = 1'b0;
        host_gnt    = 1'b0;
        host_forced = (wait_cnt == WAIT_W'(HOST_MAX_WAIT));
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        pipe_first  = (state != ST_PIPE_OWN);
`else
        pipe_first  = 1'b1;
`endif
        if (!reset) begin
            if (state == ST_HOST_LOCK) begin
                host_gnt = host_req;
            end else if (pipe_req && host_req) begin
                if (host_forced || !pipe_first) begin
                    host_gnt = 1'b1;
                end else begin
                    pipe_gnt = 1'b1;
                end
            end else begin
                pipe_gnt = pipe_req;
                host_gnt = host_req;
            end
        end
        pipe_stall = pipe_req & ~pipe_gnt;
    end

    // Memory port mux; address and write data hold their last granted values.
    always_comb begin
        mem_we    = (pipe_gnt & pipe_we) | (host_gnt & host_we);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (reset) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else if (pipe_gnt) begin
            mem_addr  = pipe_addr;
            mem_wdata = pipe_wdata;
        end else if (host_gnt) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    // Next winner state and host starvation counter.
    always_comb begin
        state_next    = ST_IDLE;
        wait_cnt_next = '0;
        if (host_gnt) begin
            state_next = host_lock ? ST_HOST_LOCK : ST_HOST_OWN;
        end else if (pipe_gnt) begin
            state_next = ST_PIPE_OWN;
        end
        if (host_req && !host_gnt) begin
            wait_cnt_next = (wait_cnt < WAIT_W'(HOST_MAX_WAIT)) ? wait_cnt + WAIT_W'(1) : wait_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            pipe_pend    <= 1'b0;
            host_pend    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            pipe_rdata_q <= '0;
            host_rdata_q <= '0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_cnt_next;
            pipe_pend <= pipe_gnt & ~pipe_we;
            host_pend <= host_gnt & ~host_we;
            if (pipe_gnt || host_gnt) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
            if (pipe_pend) begin
                pipe_rdata_q <= mem_rdata;
            end
            if (host_pend) begin
                host_rdata_q <= mem_rdata;
            end
        end
    end

    // Read data arrives one cycle after the grant; a reset in that cycle kills the response.
    always_comb begin
        pipe_rvalid = pipe_pend & ~reset;
        host_rvalid = host_pend & ~reset;
        pipe_rdata  = reset ? '0 : (pipe_pend ? mem_rdata : pipe_rdata_q);
        host_rdata  = reset ? '0 : (host_pend ? mem_rdata : host_rdata_q);
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter; expectations follow DMEM_ARB_ROUND_ROBIN_EN when defined.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int unsigned DW  = 64;
    localparam int unsigned AW  = 8;
    localparam int unsigned HMW = 4;

    typedef struct {
        bit          pg;
        bit          hg;
        bit          stall;
        bit          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } gexp_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } rexp_t;

    logic          clk;
    logic          reset;
    logic          pipe_req, pipe_we, pipe_gnt, pipe_stall, pipe_rvalid;
    logic [AW-1:0] pipe_addr;
    logic [DW-1:0] pipe_wdata, pipe_rdata;
    logic          host_req, host_we, host_lock, host_gnt, host_rvalid;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata, host_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] mem [256];
    gexp_t         gq[$];
    rexp_t         pq[$];
    rexp_t         hq[$];
    int            cyc;
    int            checks;
    int            errors;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .HOST_MAX_WAIT(HMW)) dut (
        .clk(clk), .reset(reset),
        .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
        .pipe_gnt(pipe_gnt), .pipe_stall(pipe_stall), .pipe_rvalid(pipe_rvalid), .pipe_rdata(pipe_rdata),
        .host_req(host_req), .host_we(host_we), .host_lock(host_lock), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle-latency memory model, read-before-write.
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares grants every cycle and read responses when due.
    always @(negedge clk) begin
        gexp_t g;
        rexp_t r;
        if (gq.size() > 0) begin
            g = gq.pop_front();
            chk("pipe_gnt", 64'(pipe_gnt), 64'(g.pg));
            chk("host_gnt", 64'(host_gnt), 64'(g.hg));
            chk("pipe_stall", 64'(pipe_stall), 64'(g.stall));
            chk("mem_we", 64'(mem_we), 64'(g.we));
            chk("mem_addr", 64'(mem_addr), 64'(g.addr));
            chk("mem_wdata", mem_wdata, g.wdata);
        end
        chk("both_gnt", 64'(pipe_gnt & host_gnt), 64'd0);
        if (pq.size() > 0 && pq[0].cyc == cyc) begin
            r = pq.pop_front();
            chk("pipe_rvalid", 64'(pipe_rvalid), 64'd1);
            chk("pipe_rdata", pipe_rdata, r.data);
        end else begin
            chk("pipe_rvalid_idle", 64'(pipe_rvalid), 64'd0);
        end
        if (hq.size() > 0 && hq[0].cyc == cyc) begin
            r = hq.pop_front();
            chk("host_rvalid", 64'(host_rvalid), 64'd1);
            chk("host_rdata", host_rdata, r.data);
        end else begin
            chk("host_rvalid_idle", 64'(host_rvalid), 64'd0);
        end
    end

    // Drive one cycle of stimulus and push its expected response.
    task automatic step(input bit rst,
                        input bit preq, input bit pwe, input logic [AW-1:0] paddr, input logic [DW-1:0] pwd,
                        input bit hreq, input bit hwe, input bit hlock, input logic [AW-1:0] haddr,
                        input logic [DW-1:0] hwd,
                        input bit epg, input bit ehg, input logic [DW-1:0] erd);
        gexp_t g;
        rexp_t r;
        @(posedge clk);
        #1;
        reset = rst;
        pipe_req = preq; pipe_we = pwe; pipe_addr = paddr; pipe_wdata = pwd;
        host_req = hreq; host_we = hwe; host_lock = hlock; host_addr = haddr; host_wdata = hwd;
        if (rst) begin
            exp_addr  = '0;
            exp_wdata = '0;
            while (pq.size() > 0 && pq[$].cyc == cyc) void'(pq.pop_back());
            while (hq.size() > 0 && hq[$].cyc == cyc) void'(hq.pop_back());
        end else if (epg) begin
            exp_addr  = paddr;
            exp_wdata = pwd;
        end else if (ehg) begin
            exp_addr  = haddr;
            exp_wdata = hwd;
        end
        g.pg = epg; g.hg = ehg; g.stall = preq & ~epg;
        g.we = (epg & pwe) | (ehg & hwe);
        g.addr = exp_addr; g.wdata = exp_wdata;
        gq.push_back(g);
        r.cyc = cyc + 1;
        r.data = erd;
        if (epg && !pwe) pq.push_back(r);
        if (ehg && !hwe) hq.push_back(r);
    endtask

    task automatic idle();
        step(0, 0, 0, 8'h00, '0, 0, 0, 0, 8'h00, '0, 0, 0, '0);
    endtask

    task automatic p_only(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input bit epg, input logic [DW-1:0] erd);
        step(0, 1, we, a, wd, 0, 0, 0, 8'h00, '0, epg, 0, erd);
    endtask

    task automatic h_only(input bit we, input bit lock, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [DW-1:0] erd);
        step(0, 0, 0, 8'h00, '0, 1, we, lock, a, wd, 0, 1, erd);
    endtask

    // Contention of two reads (pipe 0x01, host 0x02); i counts from a fresh IDLE with counter 0.
    function automatic bit host_wins(input int i);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        return (i % 2) == 1;
`else
        return (i % 5) == 4;
`endif
    endfunction

    task automatic contend(input int i);
        bit hw;
        hw = host_wins(i);
        step(0, 1, 0, 8'h01, '0, 1, 0, 0, 8'h02, '0, !hw, hw, hw ? 64'h1002 : 64'h1001);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 64'h1000 + 64'(i);
        mem[8'h10] = 64'hA5;
        reset = 1'b1;
        pipe_req = 0; pipe_we = 0; pipe_addr = '0; pipe_wdata = '0;
        host_req = 0; host_we = 0; host_lock = 0; host_addr = '0; host_wdata = '0;
        exp_addr = '0; exp_wdata = '0;

        // Requests under reset are never granted.
        step(1, 1, 0, 8'h33, '0, 1, 0, 0, 8'h44, '0, 0, 0, '0);
        step(1, 1, 0, 8'h33, '0, 1, 0, 0, 8'h44, '0, 0, 0, '0);
        idle();

        // Single-requester traffic.
        p_only(0, 8'h10, '0, 1, 64'hA5);
        p_only(1, 8'h11, 64'hDEAD, 1, '0);
        p_only(0, 8'h11, '0, 1, 64'hDEAD);
        h_only(0, 0, 8'h05, '0, 64'h1005);
        idle();

        // Continuous contention.
        for (int i = 0; i < 10; i++) contend(i);
        idle();

        // Host lock held for three cycles, released with a final unlocked write.
        h_only(1, 1, 8'h20, 64'h1234, '0);
        step(0, 1, 0, 8'h10, '0, 1, 1, 1, 8'h20, 64'h1234, 0, 1, '0);
        step(0, 1, 0, 8'h10, '0, 1, 1, 1, 8'h20, 64'h1234, 0, 1, '0);
        step(0, 1, 0, 8'h10, '0, 1, 1, 0, 8'h21, 64'h55, 0, 1, '0);
        p_only(0, 8'h20, '0, 1, 64'h1234);
        idle();

        // Lock left by the host dropping its request: pipe still waits one cycle.
        h_only(0, 1, 8'h21, '0, 64'h55);
        p_only(0, 8'h10, '0, 0, '0);
        p_only(0, 8'h10, '0, 1, 64'hA5);
        idle();

        // Reset while a locked host read is in flight.
        h_only(0, 1, 8'h30, '0, 64'h1030);
        step(1, 1, 0, 8'h01, '0, 1, 0, 0, 8'h02, '0, 0, 0, '0);
        contend(0);
        idle();

        // Reset clears a partially built host-wait count.
        for (int i = 0; i < 3; i++) contend(i);
        step(1, 1, 0, 8'h01, '0, 1, 0, 0, 8'h02, '0, 0, 0, '0);
        for (int i = 0; i < 5; i++) contend(i);

        idle();
        idle();
        idle();
        @(negedge clk);
        #1;
        chk("grant_queue_drained", 64'(gq.size()), 64'd0);
        chk("pipe_reads_drained", 64'(pq.size()), 64'd0);
        chk("host_reads_drained", 64'(hq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, data-memory word address width.
REQ-003 SHALL have parameter HOST_MAX_WAIT, default 4, consecutive denied host cycles before host is forced to win.
REQ-004 SHALL have port clk, input, 1, clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have ports pipe_req/pipe_we, input, 1 each, pipeline memory-stage request and write flag.
REQ-007 SHALL have ports pipe_addr, input, ADDR_WIDTH, and pipe_wdata, input, DATA_WIDTH.
REQ-008 SHALL have ports pipe_gnt, output, 1; pipe_stall, output, 1; pipe_rvalid, output, 1; pipe_rdata, output, DATA_WIDTH.
REQ-009 SHALL have ports host_req/host_we/host_lock, input, 1 each; host_addr, input, ADDR_WIDTH; host_wdata, input, DATA_WIDTH.
REQ-010 SHALL have ports host_gnt, output, 1; host_rvalid, output, 1; host_rdata, output, DATA_WIDTH.
REQ-011 SHALL have ports mem_we, output, 1; mem_addr, output, ADDR_WIDTH; mem_wdata, output, DATA_WIDTH; mem_rdata, input, DATA_WIDTH (memory read latency exactly 1 cycle).

Function
REQ-012 Each granted access SHALL be single-cycle; gnt combinational from current req and state; winner's we/addr/wdata SHALL drive mem_* that cycle.
REQ-013 With no grant, mem_we SHALL be 0; mem_addr/mem_wdata SHALL hold last values.
REQ-014 Granted read SHALL return mem_rdata on owner's rdata with owner's rvalid high exactly 1 cycle after gnt; writes SHALL produce no rvalid.
REQ-015 pipe_stall SHALL equal pipe_req AND NOT pipe_gnt.
REQ-016 FSM states: IDLE, PIPE_OWN, HOST_OWN, HOST_LOCK; state SHALL record last winner (IDLE when neither granted).
REQ-017 Only one requester: it SHALL be granted, except in HOST_LOCK (see REQ-019).
REQ-018 Simultaneous requests, default policy: pipeline wins, unless host-wait counter equals HOST_MAX_WAIT, then host wins.
REQ-019 Host granted with host_lock=1 SHALL enter HOST_LOCK; pipeline SHALL be denied while in HOST_LOCK; exit to HOST_OWN on the cycle host is granted with host_lock=0, or to IDLE if host_req=0.
REQ-020 Host-wait counter SHALL increment each cycle host_req=1 and host_gnt=0, saturate at HOST_MAX_WAIT, clear on host_gnt or host_req=0.
REQ-021 pipe_gnt and host_gnt SHALL never both be 1.

Reset
REQ-022 On reset: state IDLE, wait counter 0, all gnt/rvalid/mem_we 0, rdata/mem_addr/mem_wdata 0.
REQ-023 Reset while a read is in flight SHALL suppress its rvalid on the following cycle.
REQ-024 Reset while in HOST_LOCK SHALL release the lock.

Configuration
REQ-025 Macro DMEM_ARB_ROUND_ROBIN_EN defined: simultaneous requests SHALL grant the requester that did not win most recently (state PIPE_OWN -> host, HOST_OWN/IDLE -> pipeline); wait counter still forces host.
REQ-026 Macro undefined: fixed pipeline priority per REQ-018.

Structure
REQ-027 FSM state encoding and default widths SHALL live in shared package dmem_arb_pkg.
REQ-028 Single flat module; no sub-modules.

Verification
REQ-029 Pipe read addr 0x10 alone, mem holds 0xA5 -> pipe_gnt same cycle, pipe_rvalid next cycle, pipe_rdata=0xA5.
REQ-030 Both request continuously, default build, HOST_MAX_WAIT=4 -> pipe granted 4 cycles, host 5th, pattern repeats; pipe_stall=1 on host cycles.
REQ-031 Both request continuously, DMEM_ARB_ROUND_ROBIN_EN -> grants alternate pipe,host,pipe,host.
REQ-032 Host writes 0x20=0x1234 with host_lock=1 for 3 cycles, pipe_req=1 -> pipe_gnt=0 and pipe_stall=1 those cycles; pipe granted on cycle after lock drops.
REQ-033 Host read granted, reset asserted next cycle -> host_rvalid stays 0, state IDLE, counter 0.
REQ-034 Random two-requester stimulus 10k cycles -> never both gnt, every read rvalid exactly 1 cycle later to correct owner.
